ddr3_rw_arbiter: RTL and testbench

DDR3_RW_ARBITER -- requirements
Module: ddr3_rw_arbiter

---
 rtl/ddr3_rw_arbiter.sv | 173 +++++++++++++++++
 tb/tb_ddr3_rw_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr3_rw_arbiter.sv
// ddr3_rw_arbiter: read/write arbiter that feeds the MIG app command and write-data ports.
// Ports: ui_clk/ui_clk_sync_rst, calib, wr/rd request handshakes, MIG app_* port, stat_* counters.
// The stat counters exist only when ARB_STAT_EN is defined; otherwise stat_* are tied to 0.
module ddr3_rw_arbiter #(
  parameter int ADDR_W    = 30,
  parameter int DATA_W    = 512,
  parameter int BURST_MAX = 32
) (
  input  logic                ui_clk,
  input  logic                ui_clk_sync_rst,
  input  logic                init_calib_complete,

  input  logic                wr_req_valid,
  output logic                wr_req_ready,
  input  logic [ADDR_W-1:0]   wr_req_addr,
  input  logic [DATA_W-1:0]   wr_req_data,

  input  logic                rd_req_valid,
  output logic                rd_req_ready,
  input  logic [ADDR_W-1:0]   rd_req_addr,

  input  logic                app_rdy,
  input  logic                app_wdf_rdy,
  output logic                app_en,
  output logic [2:0]          app_cmd,
  output logic [ADDR_W-1:0]   app_addr,
  output logic                app_wdf_wren,
  output logic                app_wdf_end,
  output logic [DATA_W-1:0]   app_wdf_data,
  output logic [DATA_W/8-1:0] app_wdf_mask,

  output logic                app_writing,
  output logic [31:0]         stat_wr_cnt,
  output logic [31:0]         stat_rd_cnt
);

  localparam int CNT_W = $clog2(BURST_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BURST_MAX);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WR   = 2'd1;
  localparam logic [1:0] S_RD   = 2'd2;

  localparam logic [2:0] CMD_WR = 3'b000;
  localparam logic [2:0] CMD_RD = 3'b001;

  localparam logic DIR_WR = 1'b0;
  localparam logic DIR_RD = 1'b1;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
  logic             last_dir_q, last_dir_d;

  logic in_wr;
  logic in_rd;
  logic wr_en;
  logic rd_en;
  logic wr_acc;
  logic rd_acc;

  assign in_wr = (state_q == S_WR);
  assign in_rd = (state_q == S_RD);

  // Write command and data go out together: a write is only
  // offered when the data FIFO can also take the beat.
  assign wr_en  = in_wr & wr_req_valid & app_wdf_rdy
                & init_calib_complete;
  assign rd_en  = in_rd & rd_req_valid & init_calib_complete;
  assign wr_acc = wr_en & app_rdy;
  assign rd_acc = rd_en & app_rdy;

  // ---------------- MIG / handshake outputs ----------------
  assign app_en       = wr_en | rd_en;
  assign app_cmd      = in_rd ? CMD_RD : CMD_WR;
  assign app_addr     = in_wr ? wr_req_addr
                      : in_rd ? rd_req_addr
                      : '0;
  assign app_wdf_wren = wr_acc;
  assign app_wdf_end  = wr_acc;
  assign app_wdf_data = in_wr ? wr_req_data : '0;
  assign app_wdf_mask = '0;
  assign wr_req_ready = wr_acc;
  assign rd_req_ready = rd_acc;
  assign app_writing  = in_wr;

  // ---------------- next-state logic ----------------
  always_comb begin
    state_d     = state_q;
    burst_cnt_d = burst_cnt_q;
    last_dir_d  = last_dir_q;
    unique case (state_q)
      S_IDLE: begin
        if (init_calib_complete) begin
          // Both pending: turn toward whichever side did not
          // have the previous grant.
          if (wr_req_valid &&
              (!rd_req_valid || last_dir_q == DIR_RD)) begin
            state_d     = S_WR;
            burst_cnt_d = '0;
            last_dir_d  = DIR_WR;
          end else if (rd_req_valid) begin
            state_d     = S_RD;
            burst_cnt_d = '0;
            last_dir_d  = DIR_RD;
          end
        end
      end
      S_WR: begin
        if (wr_acc && burst_cnt_q != CNT_MAX)
          burst_cnt_d = burst_cnt_q + 1'b1;
        // Exit looks at the post-acceptance count so a burst is
        // exactly BURST_MAX commands long.
        if (!wr_req_valid || !init_calib_complete ||
            (burst_cnt_d == CNT_MAX && rd_req_valid))
          state_d = S_IDLE;
      end
      S_RD: begin
        if (rd_acc && burst_cnt_q != CNT_MAX)
          burst_cnt_d = burst_cnt_q + 1'b1;
        if (!rd_req_valid || !init_calib_complete ||
            (burst_cnt_d == CNT_MAX && wr_req_valid))
          state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // last_dir resets to "read" so the first contested grant is a write.
  always_ff @(posedge ui_clk or posedge ui_clk_sync_rst) begin
    if (ui_clk_sync_rst) begin
      state_q     <= S_IDLE;
      burst_cnt_q <= '0;
      last_dir_q  <= DIR_RD;
    end else begin
      state_q     <= state_d;
      burst_cnt_q <= burst_cnt_d;
      last_dir_q  <= last_dir_d;
    end
  end

  // ---------------- statistics ----------------
`ifdef ARB_STAT_EN
  logic [31:0] stat_wr_q, stat_wr_d;
  logic [31:0] stat_rd_q, stat_rd_d;

  // Free-running, wraps modulo 2^32.
  always_comb begin
    stat_wr_d = stat_wr_q;
    stat_rd_d = stat_rd_q;
    if (wr_acc) stat_wr_d = stat_wr_q + 32'd1;
    if (rd_acc) stat_rd_d = stat_rd_q + 32'd1;
  end

  always_ff @(posedge ui_clk or posedge ui_clk_sync_rst) begin
    if (ui_clk_sync_rst) begin
      stat_wr_q <= '0;
      stat_rd_q <= '0;
    end else begin
      stat_wr_q <= stat_wr_d;
      stat_rd_q <= stat_rd_d;
    end
  end

  assign stat_wr_cnt = stat_wr_q;
  assign stat_rd_cnt = stat_rd_q;
`else
  assign stat_wr_cnt = 32'd0;
  assign stat_rd_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_ddr3_rw_arbiter.sv
// tb_ddr3_rw_arbiter: directed self-checking bench for ddr3_rw_arbiter.
// Inputs change 1ns after the rising edge; outputs are checked 1ns later.
module tb_ddr3_rw_arbiter;

  localparam int AW = 30;
  localparam int DW = 512;

  logic          ui_clk = 1'b0;
  logic          ui_clk_sync_rst;
  logic          init_calib_complete;
  logic          wr_req_valid;
  logic          wr_req_ready;
  logic [AW-1:0] wr_req_addr;
  logic [DW-1:0] wr_req_data;
  logic          rd_req_valid;
  logic          rd_req_ready;
  logic [AW-1:0] rd_req_addr;
  logic          app_rdy;
  logic          app_wdf_rdy;
  logic          app_en;
  logic [2:0]    app_cmd;
  logic [AW-1:0] app_addr;
  logic          app_wdf_wren;
  logic          app_wdf_end;
  logic [DW-1:0] app_wdf_data;
  logic [DW/8-1:0] app_wdf_mask;
  logic          app_writing;
  logic [31:0]   stat_wr_cnt;
  logic [31:0]   stat_rd_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 ui_clk = ~ui_clk;

  ddr3_rw_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .BURST_MAX(32)
  ) dut (
    .ui_clk(ui_clk),
    .ui_clk_sync_rst(ui_clk_sync_rst),
    .init_calib_complete(init_calib_complete),
    .wr_req_valid(wr_req_valid),
    .wr_req_ready(wr_req_ready),
    .wr_req_addr(wr_req_addr),
    .wr_req_data(wr_req_data),
    .rd_req_valid(rd_req_valid),
    .rd_req_ready(rd_req_ready),
    .rd_req_addr(rd_req_addr),
    .app_rdy(app_rdy),
    .app_wdf_rdy(app_wdf_rdy),
    .app_en(app_en),
    .app_cmd(app_cmd),
    .app_addr(app_addr),
    .app_wdf_wren(app_wdf_wren),
    .app_wdf_end(app_wdf_end),
    .app_wdf_data(app_wdf_data),
    .app_wdf_mask(app_wdf_mask),
    .app_writing(app_writing),
    .stat_wr_cnt(stat_wr_cnt),
    .stat_rd_cnt(stat_rd_cnt)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge ui_clk);
    #1;
  endtask

  // Everything a granted write shows in one cycle.
  task automatic chk_wr(input string tag, input logic [AW-1:0] a);
    chk({tag, ".en"},   64'(app_en), 64'd1);
    chk({tag, ".cmd"},  64'(app_cmd), 64'd0);
    chk({tag, ".addr"}, 64'(app_addr), 64'(a));
    chk({tag, ".wren"}, 64'(app_wdf_wren), 64'd1);
    chk({tag, ".wrdy"}, 64'(wr_req_ready), 64'd1);
    chk({tag, ".rrdy"}, 64'(rd_req_ready), 64'd0);
    chk({tag, ".wing"}, 64'(app_writing), 64'd1);
  endtask

  task automatic chk_rd(input string tag, input logic [AW-1:0] a);
    chk({tag, ".en"},   64'(app_en), 64'd1);
    chk({tag, ".cmd"},  64'(app_cmd), 64'd1);
    chk({tag, ".addr"}, 64'(app_addr), 64'(a));
    chk({tag, ".wren"}, 64'(app_wdf_wren), 64'd0);
    chk({tag, ".wrdy"}, 64'(wr_req_ready), 64'd0);
    chk({tag, ".rrdy"}, 64'(rd_req_ready), 64'd1);
    chk({tag, ".wing"}, 64'(app_writing), 64'd0);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".en"},   64'(app_en), 64'd0);
    chk({tag, ".wren"}, 64'(app_wdf_wren), 64'd0);
    chk({tag, ".wend"}, 64'(app_wdf_end), 64'd0);
    chk({tag, ".wrdy"}, 64'(wr_req_ready), 64'd0);
    chk({tag, ".rrdy"}, 64'(rd_req_ready), 64'd0);
    chk({tag, ".wing"}, 64'(app_writing), 64'd0);
  endtask

  initial begin
    ui_clk_sync_rst     = 1'b1;
    init_calib_complete = 1'b0;
    wr_req_valid        = 1'b0;
    rd_req_valid        = 1'b0;
    wr_req_addr         = '0;
    rd_req_addr         = '0;
    wr_req_data         = {8{64'hDEAD_BEEF_0123_4567}};
    app_rdy             = 1'b0;
    app_wdf_rdy         = 1'b0;

    // ---- reset state ----
    #1;
    chk_idle("rst");
    chk("rst.addr", 64'(app_addr), 64'd0);
    chk("rst.mask", 64'(app_wdf_mask), 64'd0);
    chk("rst.swr", 64'(stat_wr_cnt), 64'd0);
    chk("rst.srd", 64'(stat_rd_cnt), 64'd0);
    step();
    step();
    ui_clk_sync_rst = 1'b0;

    // ---- both valid: WR first, 32/idle/32/idle/WR ----
    init_calib_complete = 1'b1;
    app_rdy     = 1'b1;
    app_wdf_rdy = 1'b1;
    wr_req_valid = 1'b1;
    rd_req_valid = 1'b1;
    #1;
    chk_idle("alt.idle0");
    step();
    for (int i = 0; i < 32; i++) begin
      wr_req_addr = AW'(30'h100 + i);
      #1;
      chk_wr("alt.wr", AW'(30'h100 + i));
      chk("alt.wdata", app_wdf_data[63:0], 64'hDEAD_BEEF_0123_4567);
      chk("alt.wend", 64'(app_wdf_end), 64'd1);
      step();
    end
    #1;
    chk_idle("alt.idle1");
    step();
    for (int i = 0; i < 32; i++) begin
      rd_req_addr = AW'(30'h200 + i);
      #1;
      chk_rd("alt.rd", AW'(30'h200 + i));
      step();
    end
    #1;
    chk_idle("alt.idle2");
    step();
    wr_req_addr = AW'(30'h300);
    #1;
    chk_wr("alt.wr2", AW'(30'h300));
    step();
    wr_req_valid = 1'b0;
    rd_req_valid = 1'b0;
    #1;
    chk("alt.drop.en", 64'(app_en), 64'd0);
    step();
    #1;
    chk_idle("alt.idle3");

    // ---- only writes for 100 cycles ----
    wr_req_valid = 1'b1;
    #1;
    chk_idle("solo.idle");
    step();
    for (int i = 0; i < 100; i++) begin
      wr_req_addr = AW'(30'h1000 + i);
      #1;
      chk_wr("solo.wr", AW'(30'h1000 + i));
      step();
    end

    // ---- app_rdy stall in WR ----
    app_rdy     = 1'b0;
    wr_req_addr = AW'(30'h155);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stall.en", 64'(app_en), 64'd1);
      chk("stall.cmd", 64'(app_cmd), 64'd0);
      chk("stall.addr", 64'(app_addr), 64'h155);
      chk("stall.wren", 64'(app_wdf_wren), 64'd0);
      chk("stall.wrdy", 64'(wr_req_ready), 64'd0);
      step();
    end
    app_rdy = 1'b1;
    #1;
    chk_wr("stall.acc", AW'(30'h155));
    step();
    wr_req_valid = 1'b0;
    #1;
    chk("stall.drop.en", 64'(app_en), 64'd0);
    step();

    // ---- calibration low holds everything ----
    init_calib_complete = 1'b0;
    wr_req_valid = 1'b1;
    rd_req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk_idle("cal.low");
      step();
    end
    init_calib_complete = 1'b1;
    rd_req_addr = AW'(30'h77);
    #1;
    chk_idle("cal.rise");
    step();
    #1;
    // last grant was WR, so the contested grant goes to RD
    chk_rd("cal.first", AW'(30'h77));
    step();
    init_calib_complete = 1'b0;
    #1;
    chk("cal.drop.en", 64'(app_en), 64'd0);
    chk("cal.drop.rrdy", 64'(rd_req_ready), 64'd0);
    step();
    wr_req_valid = 1'b0;
    rd_req_valid = 1'b0;
    init_calib_complete = 1'b1;
    #1;
    chk_idle("cal.idle");
    step();

    // ---- reset mid RD burst at burst_cnt 10 ----
    rd_req_valid = 1'b1;
    #1;
    chk_idle("mid.idle");
    step();
    for (int i = 0; i < 10; i++) begin
      rd_req_addr = AW'(30'h400 + i);
      #1;
      chk_rd("mid.rd", AW'(30'h400 + i));
      step();
    end
    wr_req_valid = 1'b1;
    ui_clk_sync_rst = 1'b1;
    #1;
    chk_idle("mid.rst");
    chk("mid.rst.cmd", 64'(app_cmd), 64'd0);
    chk("mid.rst.addr", 64'(app_addr), 64'd0);
    chk("mid.rst.swr", 64'(stat_wr_cnt), 64'd0);
    chk("mid.rst.srd", 64'(stat_rd_cnt), 64'd0);
    step();
    ui_clk_sync_rst = 1'b0;
    #1;
    chk_idle("mid.post");
    step();
    wr_req_addr = AW'(30'h500);
    #1;
    chk_wr("mid.grant", AW'(30'h500));
    step();

    // ---- statistics: 37 writes, 12 reads ----
    wr_req_valid = 1'b0;
    rd_req_valid = 1'b0;
    ui_clk_sync_rst = 1'b1;
    step();
    ui_clk_sync_rst = 1'b0;
    wr_req_valid = 1'b1;
    #1;
    chk_idle("stat.idle0");
    step();
    for (int i = 0; i < 37; i++) begin
      wr_req_addr = AW'(30'h600 + i);
      #1;
      chk_wr("stat.wr", AW'(30'h600 + i));
      step();
    end
    wr_req_valid = 1'b0;
    rd_req_valid = 1'b1;
    #1;
    chk("stat.wdrop.en", 64'(app_en), 64'd0);
    step();
    #1;
    chk_idle("stat.idle1");
    step();
    for (int i = 0; i < 12; i++) begin
      rd_req_addr = AW'(30'h700 + i);
      #1;
      chk_rd("stat.rd", AW'(30'h700 + i));
      step();
    end
    rd_req_valid = 1'b0;
    #1;
    chk("stat.rdrop.en", 64'(app_en), 64'd0);
    step();
    #1;
`ifdef ARB_STAT_EN
    chk("stat.wr_cnt", 64'(stat_wr_cnt), 64'd37);
    chk("stat.rd_cnt", 64'(stat_rd_cnt), 64'd12);
`else
    chk("stat.wr_cnt", 64'(stat_wr_cnt), 64'd0);
    chk("stat.rd_cnt", 64'(stat_rd_cnt), 64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
